intercom_arbiter: RTL and testbench

Parametrised N-master to 1-slave Wishbone (classic, non-pipelined) arbiter sitting in front of the system `Intercom` bus on the 50 MHz domain. It lets the SD-card SPI engine, the HDMI frame fetcher and the user-interface logic share one slave port. Grants are round-robin and held for a whole `cyc` burst. An optional watchdog aborts stalled transfers.

---
 rtl/intercom_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_intercom_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intercom_arbiter.sv
// intercom_arbiter: N-master to 1-slave Wishbone classic arbiter, round-robin,
// grant held for a whole cyc burst; optional watchdog via `ARB_TIMEOUT_EN.
//
// Parameters:
//   NUM_MASTERS  master ports (1..16)
//   DATA_WIDTH   data bus width
//   ADDR_WIDTH   address bus width
//   SELECT_WIDTH byte-select width
//   TIMEOUT      watchdog limit in cycles (used only with ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   m_adr/m_dat_w/m_sel         packed per-master request buses (slice i)
//   m_we/m_stb/m_cyc            per-master control
//   m_dat_r                     slave read data broadcast to all masters
//   m_ack/m_err                 per-master responses (owner only)
//   s_adr/s_dat_w/s_sel/s_we/s_stb/s_cyc  slave request side
//   s_dat_r/s_ack/s_err         slave responses
//   grant                       registered one-hot owner, zero when idle

module intercom_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_w,
    input  logic [NUM_MASTERS*SELECT_WIDTH-1:0]  m_sel,
    input  logic [NUM_MASTERS-1:0]               m_we,
    input  logic [NUM_MASTERS-1:0]               m_stb,
    input  logic [NUM_MASTERS-1:0]               m_cyc,
    output logic [DATA_WIDTH-1:0]                m_dat_r,
    output logic [NUM_MASTERS-1:0]               m_ack,
    output logic [NUM_MASTERS-1:0]               m_err,
    output logic [ADDR_WIDTH-1:0]                s_adr,
    output logic [DATA_WIDTH-1:0]                s_dat_w,
    output logic [SELECT_WIDTH-1:0]              s_sel,
    output logic                                 s_we,
    output logic                                 s_stb,
    output logic                                 s_cyc,
    input  logic [DATA_WIDTH-1:0]                s_dat_r,
    input  logic                                 s_ack,
    input  logic                                 s_err,
    output logic [NUM_MASTERS-1:0]               grant
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 16) begin : g_bad_masters
        $error("intercom_arbiter: NUM_MASTERS out of range");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("intercom_arbiter: TIMEOUT must be >= 1");
    end

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;
`endif

    state_t                 state;
    state_t                 next_state;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          gidx;
    logic [PW-1:0]          ptr_next;
    logic [PW-1:0]          pick_idx;
    logic                   pick_ok;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic                   cyc_g;
    logic                   wd_fire;

    assign cyc_g = m_cyc[gidx];

    // First requester at or after ptr, searching upward with wrap.
    always_comb begin
        pick_idx = '0;
        pick_ok  = 1'b0;
        for (int off = 0; off < NUM_MASTERS; off++) begin
            if (!pick_ok && m_cyc[(int'(ptr) + off) % NUM_MASTERS]) begin
                pick_ok  = 1'b1;
                pick_idx = PW'((int'(ptr) + off) % NUM_MASTERS);
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    always_comb begin
        if (int'(gidx) >= NUM_MASTERS - 1)
            ptr_next = '0;
        else
            ptr_next = gidx + PW'(1);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;

    // Counts strobed OWN cycles without a slave response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if (state != OWN)
            wd_cnt <= '0;
        else if (s_ack || s_err)
            wd_cnt <= '0;
        else if (s_stb)
            wd_cnt <= wd_cnt + CW'(1);
    end

    assign wd_fire = (state == OWN) && (wd_cnt == CW'(TIMEOUT));
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pick_ok)
                    next_state = OWN;
            end
            OWN: begin
                if (!cyc_g)
                    next_state = IDLE;
`ifdef ARB_TIMEOUT_EN
                else if (wd_fire)
                    next_state = ABORT;
`endif
            end
`ifdef ARB_TIMEOUT_EN
            ABORT: begin
                if (!cyc_g)
                    next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && pick_ok) begin
                grant <= pick_oh;
                gidx  <= pick_idx;
            end else if (state != IDLE && next_state == IDLE) begin
                grant <= '0;
                ptr   <= ptr_next;
            end
        end
    end

    // Slave side follows the owner only in OWN; IDLE and ABORT drive zeros.
    // Every output here depends on registered state, so reset clears them
    // without waiting for a clock edge.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_stb   = 1'b0;
        s_cyc   = 1'b0;
        m_ack   = '0;
        m_err   = '0;
        m_dat_r = s_dat_r;
        if (state == OWN) begin
            s_adr   = m_adr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_w = m_dat_w[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            s_sel   = m_sel[int'(gidx)*SELECT_WIDTH +: SELECT_WIDTH];
            s_we    = m_we[gidx];
            s_cyc   = cyc_g & ~wd_fire;
            s_stb   = m_stb[gidx] & cyc_g & ~wd_fire;
            m_ack[gidx] = s_ack & ~wd_fire;
            m_err[gidx] = s_err | wd_fire;
        end
    end

endmodule

// File: tb/tb_intercom_arbiter.sv
// tb_intercom_arbiter: directed bench for intercom_arbiter (4 masters,
// TIMEOUT = 8); watchdog scenario follows `ARB_TIMEOUT_EN.

module tb_intercom_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat_w;
    logic [N*SW-1:0]   m_sel;
    logic [N-1:0]      m_we;
    logic [N-1:0]      m_stb;
    logic [N-1:0]      m_cyc;
    logic [DW-1:0]     m_dat_r;
    logic [N-1:0]      m_ack;
    logic [N-1:0]      m_err;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_w;
    logic [SW-1:0]     s_sel;
    logic              s_we;
    logic              s_stb;
    logic              s_cyc;
    logic [DW-1:0]     s_dat_r;
    logic              s_ack;
    logic              s_err;
    logic [N-1:0]      grant;

    int nvec  = 0;
    int nfail = 0;

    intercom_arbiter #(
        .NUM_MASTERS (N),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SELECT_WIDTH(SW),
        .TIMEOUT     (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_adr  (m_adr),
        .m_dat_w(m_dat_w),
        .m_sel  (m_sel),
        .m_we   (m_we),
        .m_stb  (m_stb),
        .m_cyc  (m_cyc),
        .m_dat_r(m_dat_r),
        .m_ack  (m_ack),
        .m_err  (m_err),
        .s_adr  (s_adr),
        .s_dat_w(s_dat_w),
        .s_sel  (s_sel),
        .s_we   (s_we),
        .s_stb  (s_stb),
        .s_cyc  (s_cyc),
        .s_dat_r(s_dat_r),
        .s_ack  (s_ack),
        .s_err  (s_err),
        .grant  (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic setm(input int i, input logic cyc, input logic stb,
                        input logic we, input logic [31:0] adr,
                        input logic [31:0] dat);
        m_cyc[i]              = cyc;
        m_stb[i]              = stb;
        m_we[i]               = we;
        m_adr[i*AW +: AW]     = adr;
        m_dat_w[i*DW +: DW]   = dat;
        m_sel[i*SW +: SW]     = 4'hF;
    endtask

    logic [3:0]  e;
    logic [31:0] ea;
    int          own_cnt;
    int          err_cnt;

    initial begin
        rst     = 1'b0;
        m_adr   = '0;
        m_dat_w = '0;
        m_sel   = '0;
        m_we    = '0;
        m_stb   = '0;
        m_cyc   = '0;
        s_dat_r = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_scyc", s_cyc, 0);
        check("rst_ack", m_ack, 0);
        check("rst_err", m_err, 0);
        step();
        step();
        rst = 1'b1;

        // Single master read, slave acks two cycles after stb.
        setm(0, 1, 1, 0, 32'h0000_1000, 0);
        #1;
        check("t1_grant_pre", grant, 0);
        check("t1_scyc_pre", s_cyc, 0);
        step();
        check("t1_grant", grant, 4'b0001);
        check("t1_scyc", s_cyc, 1);
        check("t1_sstb", s_stb, 1);
        check("t1_sadr", s_adr, 32'h0000_1000);
        step();
        check("t1_noack", m_ack, 0);
        step();
        s_ack   = 1'b1;
        s_dat_r = 32'hDEAD_BEEF;
        #1;
        check("t1_ack", m_ack, 4'b0001);
        check("t1_datr", m_dat_r, 32'hDEAD_BEEF);
        step();
        s_ack = 1'b0;
        setm(0, 0, 0, 0, 0, 0);
        #1;
        check("t1_ack_end", m_ack, 0);
        check("t1_release", s_cyc, 0);
        step();
        check("t1_idle", grant, 0);

        // Reset to bring ptr back to 0, then four simultaneous writers.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            setm(i, 1, 1, 1, 32'hA000_0000 + 32'(i) * 16,
                 32'h1111_1111 * 32'(i + 1));
        step();
        for (int i = 0; i < 4; i++) begin
            e  = 4'b0001 << i;
            ea = 32'hA000_0000 + 32'(i) * 16;
            check("t2_grant", grant, e);
            check("t2_sadr", s_adr, ea);
            check("t2_sdat", s_dat_w, 32'h1111_1111 * 32'(i + 1));
            check("t2_swe", s_we, 1);
            s_ack = 1'b1;
            #1;
            check("t2_ack", m_ack, e);
            step();
            s_ack = 1'b0;
            setm(i, 0, 0, 0, 0, 0);
            #1;
            check("t2_release", s_cyc, 0);
            step();
            check("t2_gap_grant", grant, 0);
            check("t2_gap_scyc", s_cyc, 0);
            step();
        end

        // Fairness: master 2 waits behind master 0, then beats its re-request.
        setm(0, 1, 1, 0, 32'h0000_00C0, 0);
        step();
        check("t3_g0", grant, 4'b0001);
        setm(2, 1, 1, 0, 32'h0000_02C0, 0);
        s_ack = 1'b1;
        #1;
        check("t3_sadr0", s_adr, 32'h0000_00C0);
        check("t3_ack0", m_ack, 4'b0001);
        step();
        s_ack = 1'b0;
        setm(0, 0, 0, 0, 0, 0);
        step();
        setm(0, 1, 1, 0, 32'h0000_00C4, 0);
        step();
        check("t3_g2", grant, 4'b0100);
        check("t3_sadr2", s_adr, 32'h0000_02C0);
        s_ack = 1'b1;
        #1;
        check("t3_ack2", m_ack, 4'b0100);
        step();
        s_ack = 1'b0;
        setm(2, 0, 0, 0, 0, 0);
        step();
        step();
        check("t3_g0_again", grant, 4'b0001);
        check("t3_sadr0b", s_adr, 32'h0000_00C4);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        setm(0, 0, 0, 0, 0, 0);
        step();
        step();

        // Reset in the middle of master 1's burst.
        setm(1, 1, 1, 1, 32'h0000_1100, 32'h5555_AAAA);
        step();
        check("t4_g1", grant, 4'b0010);
        s_ack = 1'b1;
        #1;
        check("t4_ack1", m_ack, 4'b0010);
        rst = 1'b0;
        #1;
        check("t4_rst_scyc", s_cyc, 0);
        check("t4_rst_grant", grant, 0);
        check("t4_rst_ack", m_ack, 0);
        s_ack = 1'b0;
        setm(1, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        setm(3, 1, 1, 0, 32'h0000_3300, 0);
        step();
        check("t4_g3", grant, 4'b1000);
        check("t4_sadr3", s_adr, 32'h0000_3300);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        setm(3, 0, 0, 0, 0, 0);
        step();
        step();

        // Stalled slave: master 2 reads, master 3 queues behind it.
        setm(2, 1, 1, 0, 32'h0000_2200, 0);
        step();
        check("t5_g2", grant, 4'b0100);
        setm(3, 1, 1, 0, 32'h0000_3304, 0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            check("t5_wait_err", m_err, 0);
            check("t5_wait_stb", s_stb, 1);
            step();
        end
        check("t5_err", m_err, 4'b0100);
        check("t5_err_scyc", s_cyc, 0);
        check("t5_err_sstb", s_stb, 0);
        step();
        check("t5_err_pulse", m_err, 0);
        s_ack = 1'b1;
        #1;
        check("t5_late_ack", m_ack, 0);
        check("t5_abort_scyc", s_cyc, 0);
        check("t5_abort_grant", grant, 4'b0100);
        step();
        s_ack = 1'b0;
        setm(2, 0, 0, 0, 0, 0);
        step();
`else
        own_cnt = 0;
        err_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            if (s_cyc && grant == 4'b0100)
                own_cnt++;
            if (m_err != 0)
                err_cnt++;
            step();
        end
        check("t5_hold", own_cnt, 1000);
        check("t5_no_err", err_cnt, 0);
        setm(2, 0, 0, 0, 0, 0);
        #1;
        check("t5_release", s_cyc, 0);
        step();
`endif
        check("t5_gap", grant, 0);
        step();
        check("t5_g3", grant, 4'b1000);
        check("t5_sadr3", s_adr, 32'h0000_3304);
        setm(3, 0, 0, 0, 0, 0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
